// File: rtl/multi_pulse_sync.sv
// multi_pulse_sync: synchronize, debounce and edge-detect CH async inputs with saturating event counters (MPS_PEND_EN adds sticky pending bits)
module multi_pulse_sync #(
  parameter int CH   = 4,
  parameter int SYNC = 3,
  parameter int FILT = 4,
  parameter int CNTW = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CH-1:0]     SIG_I,
  input  logic [2*CH-1:0]   EDGE_SEL,
  input  logic              CNT_CLR,
  output logic [CH-1:0]     LVL_O,
  output logic [CH-1:0]     SIG_O,
  output logic [CH*CNTW-1:0] CNT_O,
  output logic [CH-1:0]     OVF_O
`ifdef MPS_PEND_EN
  ,
  input  logic [CH-1:0]     PEND_CLR,
  output logic [CH-1:0]     PEND_O
`endif
);
  localparam int FW = $clog2(FILT + 1);
  logic [CH-1:0] sync_q [SYNC];
  logic [CH-1:0] sync_d [SYNC];
  logic [FW-1:0] fcnt_q [CH];
  logic [FW-1:0] fcnt_d [CH];
  logic [CNTW-1:0] cnt_q [CH];
  logic [CNTW-1:0] cnt_d [CH];
  logic [CH-1:0] lvl_q, lvl_d, sig_q, sig_d, ovf_q, ovf_d, s, tr, sat;
  always_comb begin
    sync_d[0] = SIG_I;
    for (int k = 1; k < SYNC; k++) sync_d[k] = sync_q[k-1];
    s = sync_q[SYNC-1];
    fcnt_d = fcnt_q;
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    sig_d = '0;
    ovf_d = ovf_q;
    tr = '0;
    sat = '0;
    for (int i = 0; i < CH; i++) begin
      tr[i] = s[i] != lvl_q[i] && fcnt_q[i] == FW'(FILT - 1);
      fcnt_d[i] = (s[i] == lvl_q[i] || tr[i]) ? '0 : fcnt_q[i] + 1'b1;
      lvl_d[i] = tr[i] ? s[i] : lvl_q[i];
      sig_d[i] = tr[i] && (s[i] ? EDGE_SEL[2*i] : EDGE_SEL[2*i+1]);
      sat[i] = cnt_q[i] == '1;
      // a clear coinciding with an event leaves that event counted
      cnt_d[i] = CNT_CLR ? CNTW'(sig_d[i]) : (sig_d[i] && !sat[i]) ? cnt_q[i] + 1'b1 : cnt_q[i];
      ovf_d[i] = !CNT_CLR && (ovf_q[i] || (sig_d[i] && sat[i]));
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '{default: '0};
      fcnt_q <= '{default: '0};
      cnt_q  <= '{default: '0};
      lvl_q  <= '0;
      sig_q  <= '0;
      ovf_q  <= '0;
    end else begin
      sync_q <= sync_d;
      fcnt_q <= fcnt_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      sig_q  <= sig_d;
      ovf_q  <= ovf_d;
    end
  end
  assign LVL_O = lvl_q;
  assign SIG_O = sig_q;
  assign OVF_O = ovf_q;
  for (genvar g = 0; g < CH; g++) begin : g_cnt
    assign CNT_O[CNTW*g +: CNTW] = cnt_q[g];
  end
`ifdef MPS_PEND_EN
  logic [CH-1:0] pend_q, pend_d;
  always_comb pend_d = sig_d | (pend_q & ~PEND_CLR);
  always_ff @(posedge CLK) begin
    if (RST) pend_q <= '0;
    else pend_q <= pend_d;
  end
  assign PEND_O = pend_q;
`endif
endmodule

// File: tb/tb_multi_pulse_sync.sv
// tb_multi_pulse_sync: window-based behavioural model plus directed literal checks for multi_pulse_sync
module tb_multi_pulse_sync;
  localparam int CH = 4, SYNC = 3, FILT = 4;
  logic clk = 0, rst = 1, cnt_clr = 0;
  logic [CH-1:0] sig_i = '0;
  logic [2*CH-1:0] edge_sel = '0;
  logic [CH-1:0] lvl_o, sig_o, ovf_o, lvl_s, sig_s, ovf_s;
  logic [CH*8-1:0] cnt_o;
  logic [CH*2-1:0] cnt_s;
  int checks = 0, failures = 0;
`ifdef MPS_PEND_EN
  logic [CH-1:0] pend_clr = '0, pend_o, pend_s, m_pend;
`endif

  always #5 clk = ~clk;

  multi_pulse_sync u_dut (
    .CLK(clk), .RST(rst), .SIG_I(sig_i), .EDGE_SEL(edge_sel), .CNT_CLR(cnt_clr),
    .LVL_O(lvl_o), .SIG_O(sig_o), .CNT_O(cnt_o), .OVF_O(ovf_o)
`ifdef MPS_PEND_EN
    , .PEND_CLR(pend_clr), .PEND_O(pend_o)
`endif
  );
  multi_pulse_sync #(.CNTW(2)) u_sat (
    .CLK(clk), .RST(rst), .SIG_I(sig_i), .EDGE_SEL(edge_sel), .CNT_CLR(cnt_clr),
    .LVL_O(lvl_s), .SIG_O(sig_s), .CNT_O(cnt_s), .OVF_O(ovf_s)
`ifdef MPS_PEND_EN
    , .PEND_CLR(pend_clr), .PEND_O(pend_s)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: the level flips once FILT consecutive synchronized samples since
  // the last flip or reset all disagree with it; the synchronized sample at
  // edge k is the input captured at edge k-SYNC.
  logic [CH-1:0] raw [4096];
  int n = 0, rst_edge = 0;
  int last_change [CH];
  int c8 [CH], c2 [CH];
  logic [CH-1:0] m_lvl = '0, m_sig = '0, m_ovf8 = '0, m_ovf2 = '0;
  bit seen = 0;

  function automatic bit s_at(int k, int i);
    int j = k - SYNC;
    return (j > rst_edge) ? raw[j][i] : 1'b0;
  endfunction

  always @(posedge clk) begin
    n = n + 1;
    if (rst) begin
      rst_edge = n;
      seen = 1;
      m_lvl = '0; m_sig = '0; m_ovf8 = '0; m_ovf2 = '0;
`ifdef MPS_PEND_EN
      m_pend = '0;
`endif
      for (int i = 0; i < CH; i++) begin
        c8[i] = 0; c2[i] = 0; last_change[i] = n;
      end
    end else begin
      raw[n] = sig_i;
      for (int i = 0; i < CH; i++) begin
        bit flip;
        flip = (n - last_change[i]) >= FILT;
        for (int k = 0; k < FILT; k++) if (s_at(n - k, i) == m_lvl[i]) flip = 0;
        m_sig[i] = flip && (m_lvl[i] ? edge_sel[2*i+1] : edge_sel[2*i]);
        if (flip) begin
          m_lvl[i] = !m_lvl[i];
          last_change[i] = n;
        end
        if (cnt_clr) begin
          c8[i] = m_sig[i]; c2[i] = m_sig[i]; m_ovf8[i] = 0; m_ovf2[i] = 0;
        end else if (m_sig[i]) begin
          if (c8[i] == 255) m_ovf8[i] = 1; else c8[i]++;
          if (c2[i] == 3) m_ovf2[i] = 1; else c2[i]++;
        end
`ifdef MPS_PEND_EN
        m_pend[i] = m_sig[i] | (m_pend[i] & ~pend_clr[i]);
`endif
      end
    end
  end

  always @(negedge clk) if (seen) begin
    chk("model_lvl", lvl_o, m_lvl);
    chk("model_sig", sig_o, m_sig);
    chk("model_ovf", ovf_o, m_ovf8);
    chk("model_lvl_sat", lvl_s, m_lvl);
    chk("model_sig_sat", sig_s, m_sig);
    chk("model_ovf_sat", ovf_s, m_ovf2);
    for (int i = 0; i < CH; i++) begin
      chk("model_cnt", cnt_o[8*i +: 8], c8[i]);
      chk("model_cnt_sat", cnt_s[2*i +: 2], c2[i]);
    end
`ifdef MPS_PEND_EN
    chk("model_pend", pend_o, m_pend);
`endif
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    sig_i = 4'b0010;
    edge_sel = 8'b01010101;
    cyc(4);
    chk("reset_lvl", lvl_o, 0);
    chk("reset_cnt", cnt_o, 0);
    rst = 0;
    cyc(6);
    chk("startup_lvl_early", lvl_o, 4'b0000);
    cyc(1);
    chk("startup_lvl", lvl_o, 4'b0010);
    chk("startup_sig", sig_o, 4'b0010);
    chk("startup_cnt", cnt_o, 32'h0000_0100);
    cyc(1);
    chk("startup_sig_one_cycle", sig_o, 4'b0000);
    // debounce: 3-cycle glitch ignored, 10-cycle pulse counted twice
    edge_sel = 8'b01010111;
    sig_i[0] = 1; cyc(3); sig_i[0] = 0; cyc(15);
    chk("glitch_lvl", lvl_o, 4'b0010);
    chk("glitch_cnt", cnt_o[7:0], 0);
    sig_i[0] = 1; cyc(7);
    chk("deb_rise_sig", sig_o, 4'b0001);
    chk("deb_rise_lvl", lvl_o, 4'b0011);
    cyc(3); sig_i[0] = 0; cyc(7);
    chk("deb_fall_sig", sig_o, 4'b0001);
    chk("deb_fall_lvl", lvl_o, 4'b0010);
    cyc(2);
    chk("deb_cnt", cnt_o[7:0], 2);
    // mode select on a shared square wave
    sig_i = '0; cyc(10);
    cnt_clr = 1; cyc(1); cnt_clr = 0;
    edge_sel = 8'b11100100;
    for (int p = 0; p < 3; p++) begin
      sig_i = 4'hF; cyc(20);
      chk("mode_lvl_high", lvl_o, 4'hF);
      sig_i = 4'h0; cyc(20);
    end
    cyc(10);
    chk("mode_cnt", cnt_o, {8'd6, 8'd3, 8'd3, 8'd0});
    chk("mode_lvl", lvl_o, 4'h0);
    chk("mode_ovf_sat", ovf_s, 4'b1000);
    // saturation, then clear coinciding with an event
    cnt_clr = 1; cyc(1); cnt_clr = 0;
    edge_sel = 8'b00010000;
    for (int p = 0; p < 5; p++) begin
      sig_i[2] = 1; cyc(10); sig_i[2] = 0; cyc(10);
    end
    cyc(10);
    chk("sat_cnt", cnt_s[5:4], 3);
    chk("sat_ovf", ovf_s[2], 1);
    chk("sat_cnt_wide", cnt_o[23:16], 5);
    sig_i[2] = 1; cyc(6);
    cnt_clr = 1; cyc(1); cnt_clr = 0;
    chk("clr_event_sig", sig_s[2], 1);
    chk("clr_event_cnt", cnt_s[5:4], 1);
    chk("clr_event_ovf", ovf_s[2], 0);
    sig_i[2] = 0; cyc(10);
    // reset in the middle of a debounce
    edge_sel = 8'b01010101;
    sig_i = 4'b0001; cyc(2);
    rst = 1; cyc(1);
    chk("midrst_lvl", lvl_o, 0);
    chk("midrst_sig", sig_o, 0);
    chk("midrst_cnt", cnt_o, 0);
    chk("midrst_ovf", ovf_s, 0);
    rst = 0; cyc(6);
    chk("midrst_lvl_early", lvl_o, 0);
    cyc(1);
    chk("midrst_lvl_late", lvl_o, 4'b0001);
    chk("midrst_sig_late", sig_o, 4'b0001);
`ifdef MPS_PEND_EN
    edge_sel = 8'b11000000;
    sig_i[3] = 1; cyc(8);
    chk("pend_set", pend_o[3], 1);
    sig_i[3] = 0; cyc(6);
    pend_clr = 4'b1000; cyc(1); pend_clr = '0;
    chk("pend_sig", sig_o[3], 1);
    chk("pend_set_wins", pend_o[3], 1);
    cyc(3);
    pend_clr = 4'b1000; cyc(1); pend_clr = '0;
    chk("pend_clear", pend_o[3], 0);
`endif
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
